// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: shared encodings for the LSU-to-memory-bus controller.
//   - load/store select values
//   - 3-bit access width/sign codes (funct3 encoding)
//   - controller FSM states
//   - byte-lane size masks and a helper to pick one from the size bits
package lsu_mem_ctrl_pkg;

  localparam logic LsLoad  = 1'b0;
  localparam logic LsStore = 1'b1;

  localparam logic [2:0] WdthB   = 3'b000;
  localparam logic [2:0] WdthH   = 3'b001;
  localparam logic [2:0] WdthW   = 3'b010;
  localparam logic [2:0] WdthD   = 3'b011;
  localparam logic [2:0] WdthBu  = 3'b100;
  localparam logic [2:0] WdthHu  = 3'b101;
  localparam logic [2:0] WdthWu  = 3'b110;
  localparam logic [2:0] WdthIll = 3'b111;

  localparam logic [7:0] MaskB = 8'h01;
  localparam logic [7:0] MaskH = 8'h03;
  localparam logic [7:0] MaskW = 8'h0F;
  localparam logic [7:0] MaskD = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } state_e;

  // Byte mask for an access size given by width-code bits [1:0].
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      2'b00:   m = MaskB;
      2'b01:   m = MaskH;
      2'b10:   m = MaskW;
      default: m = MaskD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: combinational lane logic between the LSU and the 64-bit bus.
//   wdth_i     access width/sign code
//   off_i      byte offset within the 8-byte word
//   ls_i       0 = load, 1 = store
//   st_dat_i   right-aligned store data
//   rdat_i     raw 8-byte read data from the bus
//   misalign_o offset not a multiple of the access size
//   illegal_o  width code not valid for this access kind
//   wstrb_o    byte strobes for a store
//   wdat_o     store data shifted onto its byte lanes
//   ld_dat_o   load data shifted down, truncated and sign/zero-extended
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  wdth_i,
  input  logic [2:0]  off_i,
  input  logic        ls_i,
  input  logic [63:0] st_dat_i,
  input  logic [63:0] rdat_i,
  output logic        misalign_o,
  output logic        illegal_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdat_o,
  output logic [63:0] ld_dat_o
);

  logic [5:0]  shamt;
  logic [63:0] shifted;

  assign shamt   = {off_i, 3'b000};
  assign shifted = rdat_i >> shamt;
  assign wdat_o  = st_dat_i << shamt;
  assign wstrb_o = size_mask(wdth_i[1:0]) << off_i;

  // Stores only look at the size bits, so any code with bit 2 set is illegal for them.
  assign illegal_o = (ls_i == LsStore) ? wdth_i[2] : (wdth_i == WdthIll);

  always_comb begin
    case (wdth_i[1:0])
      2'b00:   misalign_o = 1'b0;
      2'b01:   misalign_o = off_i[0];
      2'b10:   misalign_o = |off_i[1:0];
      default: misalign_o = |off_i;
    endcase
  end

  always_comb begin
    case (wdth_i)
      WdthB:   ld_dat_o = {{56{shifted[7]}}, shifted[7:0]};
      WdthH:   ld_dat_o = {{48{shifted[15]}}, shifted[15:0]};
      WdthW:   ld_dat_o = {{32{shifted[31]}}, shifted[31:0]};
      WdthBu:  ld_dat_o = {56'b0, shifted[7:0]};
      WdthHu:  ld_dat_o = {48'b0, shifted[15:0]};
      WdthWu:  ld_dat_o = {32'b0, shifted[31:0]};
      default: ld_dat_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle memory bus master behind the LSU, one transaction at a time.
//   LSU side : req_valid/req_ready request handshake with addr, store data, width code,
//              load/store select and rd; one-cycle resp_valid with extended load data,
//              latched rd, write-back enable and error flag.
//   Bus side : mem_req_valid/ready request with 8-byte-aligned address, write enable,
//              lane-shifted data and byte strobes; mem_resp_valid with raw read data.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_lsu_i,
  output logic                    req_ready_lsu_o,
  input  logic [ADDR_WIDTH-1:0]   addr_lsu_i,
  input  logic [DATA_WIDTH-1:0]   st_dat_lsu_i,
  input  logic [2:0]              ls_wdth_lsu_i,
  input  logic                    ls_lsu_i,
  input  logic [RD_WIDTH-1:0]     rd_lsu_i,
  output logic                    resp_valid_lsu_o,
  output logic [DATA_WIDTH-1:0]   ld_dat_lsu_o,
  output logic [RD_WIDTH-1:0]     rd_lsu_o,
  output logic                    wrtbck_en_lsu_o,
  output logic                    err_lsu_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH-1:0]   mem_wdat_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdat_i
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   st_dat_q, st_dat_d;
  logic [2:0]              wdth_q, wdth_d;
  logic                    ls_q, ls_d;
  logic [RD_WIDTH-1:0]     rd_q, rd_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   ld_dat_q, ld_dat_d;

  logic                    idle, in_req, in_resp, req_store;
  logic [2:0]              al_wdth, al_off;
  logic                    al_ls, al_misalign, al_illegal;
  logic [7:0]              al_wstrb;
  logic [DATA_WIDTH-1:0]   al_wdat, al_ld_dat;

  assign idle      = (state_q == StIdle);
  assign in_req    = (state_q == StReq);
  assign in_resp   = (state_q == StResp);
  assign req_store = in_req & (ls_q == LsStore);

  // In IDLE the aligner checks the incoming request so errors resolve at accept time;
  // afterwards it works from the latched request.
  assign al_wdth = idle ? ls_wdth_lsu_i     : wdth_q;
  assign al_off  = idle ? addr_lsu_i[2:0]   : addr_q[2:0];
  assign al_ls   = idle ? ls_lsu_i          : ls_q;

  lsu_align u_align (
    .wdth_i     (al_wdth),
    .off_i      (al_off),
    .ls_i       (al_ls),
    .st_dat_i   (st_dat_q),
    .rdat_i     (mem_rdat_i),
    .misalign_o (al_misalign),
    .illegal_o  (al_illegal),
    .wstrb_o    (al_wstrb),
    .wdat_o     (al_wdat),
    .ld_dat_o   (al_ld_dat)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    st_dat_d = st_dat_q;
    wdth_d   = wdth_q;
    ls_d     = ls_q;
    rd_d     = rd_q;
    err_d    = err_q;
    ld_dat_d = ld_dat_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_lsu_i) begin
          addr_d   = addr_lsu_i;
          st_dat_d = st_dat_lsu_i;
          wdth_d   = ls_wdth_lsu_i;
          ls_d     = ls_lsu_i;
          rd_d     = rd_lsu_i;
          ld_dat_d = '0;
          err_d    = al_misalign | al_illegal;
          state_d  = (al_misalign | al_illegal) ? StResp : StReq;
        end
      end
      StReq: begin
        if (mem_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_valid_i) begin
          if (ls_q == LsLoad) ld_dat_d = al_ld_dat;
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      st_dat_q <= '0;
      wdth_q   <= '0;
      ls_q     <= 1'b0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      ld_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      st_dat_q <= st_dat_d;
      wdth_q   <= wdth_d;
      ls_q     <= ls_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      ld_dat_q <= ld_dat_d;
    end
  end

  assign req_ready_lsu_o  = idle;
  assign resp_valid_lsu_o = in_resp;
  assign ld_dat_lsu_o     = ld_dat_q;
  assign rd_lsu_o         = rd_q;
  assign err_lsu_o        = in_resp & err_q;
  assign wrtbck_en_lsu_o  = in_resp & (ls_q == LsLoad) & ~err_q;

  // Bus payload is only driven while a request is on the bus; zero otherwise.
  assign mem_req_valid_o = in_req;
  assign mem_addr_o      = in_req ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign mem_wen_o       = req_store;
  assign mem_wdat_o      = req_store ? al_wdat  : '0;
  assign mem_wstrb_o     = req_store ? al_wstrb : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected LSU responses and
// bus payloads into queues; a bus model and a response monitor pop and compare.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_lsu_i;
  logic        req_ready_lsu_o;
  logic [63:0] addr_lsu_i;
  logic [63:0] st_dat_lsu_i;
  logic [2:0]  ls_wdth_lsu_i;
  logic        ls_lsu_i;
  logic [4:0]  rd_lsu_i;
  logic        resp_valid_lsu_o;
  logic [63:0] ld_dat_lsu_o;
  logic [4:0]  rd_lsu_o;
  logic        wrtbck_en_lsu_o;
  logic        err_lsu_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_wen_o;
  logic [63:0] mem_wdat_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_rdat_i;

  lsu_mem_ctrl #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .RD_WIDTH   (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_lsu_i  (req_valid_lsu_i),
    .req_ready_lsu_o  (req_ready_lsu_o),
    .addr_lsu_i       (addr_lsu_i),
    .st_dat_lsu_i     (st_dat_lsu_i),
    .ls_wdth_lsu_i    (ls_wdth_lsu_i),
    .ls_lsu_i         (ls_lsu_i),
    .rd_lsu_i         (rd_lsu_i),
    .resp_valid_lsu_o (resp_valid_lsu_o),
    .ld_dat_lsu_o     (ld_dat_lsu_o),
    .rd_lsu_o         (rd_lsu_o),
    .wrtbck_en_lsu_o  (wrtbck_en_lsu_o),
    .err_lsu_o        (err_lsu_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wen_o        (mem_wen_o),
    .mem_wdat_o       (mem_wdat_o),
    .mem_wstrb_o      (mem_wstrb_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_rdat_i       (mem_rdat_i)
  );

  typedef struct {
    logic [63:0] ld;
    logic [4:0]  rd;
    logic        wb;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdat;
    logic [7:0]  wstrb;
    int          rdy_dly;
    int          resp_dly;
    logic [63:0] rdat;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;

  localparam logic LD = 1'b0;
  localparam logic ST = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input logic [63:0] addr, input logic ls, input logic [2:0] wdth,
                       input logic [63:0] st, input logic [4:0] rd, input logic [63:0] rdat,
                       input int rdy, input int rsp, input logic [63:0] exp_ld,
                       input logic exp_err, input logic [7:0] exp_strb,
                       input logic [63:0] exp_wdat, input bit track);
    int    n;
    resp_t r;
    bus_t  b;
    n = 0;
    req_valid_lsu_i = 1'b1;
    addr_lsu_i      = addr;
    ls_lsu_i        = ls;
    ls_wdth_lsu_i   = wdth;
    st_dat_lsu_i    = st;
    rd_lsu_i        = rd;
    while (!req_ready_lsu_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", {63'b0, req_ready_lsu_o}, 64'd1);
    @(posedge clk);
    #1;
    req_valid_lsu_i = 1'b0;
    r.ld  = exp_ld;
    r.rd  = rd;
    r.wb  = (ls == LD) && !exp_err;
    r.err = exp_err;
    r.lat = exp_err ? 1 : 3 + rdy + rsp;
    r.acc = cyc - 1;
    if (track) rq.push_back(r);
    if (!exp_err) begin
      b.addr     = addr & ~64'h7;
      b.wen      = ls;
      b.wdat     = exp_wdat;
      b.wstrb    = exp_strb;
      b.rdy_dly  = rdy;
      b.resp_dly = rsp;
      b.rdat     = rdat;
      bq.push_back(b);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_resp_q", 64'(rq.size()), 64'd0);
    chk("drain_bus_q", 64'(bq.size()), 64'd0);
  endtask

  // Bus slave model: holds off ready, checks payload stability, then responds.
  initial begin : bus_model
    bus_t        b;
    logic [63:0] m;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_rdat_i       = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid_o) begin
        if (bq.size() == 0) begin
          chk("bus_unexpected_req", {63'b0, mem_req_valid_o}, 64'd0);
        end else begin
          b = bq.pop_front();
          m = strb_mask(b.wstrb);
          for (int i = 0; i <= b.rdy_dly; i++) begin
            if (i > 0) @(negedge clk);
            chk("bus_valid", {63'b0, mem_req_valid_o}, 64'd1);
            chk("bus_addr", mem_addr_o, b.addr);
            chk("bus_wen", {63'b0, mem_wen_o}, {63'b0, b.wen});
            chk("bus_wstrb", {56'b0, mem_wstrb_o}, {56'b0, b.wstrb});
            chk("bus_wdat", mem_wdat_o & m, b.wdat & m);
          end
          mem_req_ready_i = 1'b1;
          @(negedge clk);
          mem_req_ready_i = 1'b0;
          repeat (b.resp_dly) @(negedge clk);
          mem_rdat_i       = b.rdat;
          mem_resp_valid_i = 1'b1;
          @(negedge clk);
          mem_resp_valid_i = 1'b0;
          mem_rdat_i       = '0;
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid_lsu_o) begin
        if (rq.size() == 0) begin
          chk("resp_unexpected", {63'b0, resp_valid_lsu_o}, 64'd0);
        end else begin
          e = rq.pop_front();
          chk("resp_ld_dat", ld_dat_lsu_o, e.ld);
          chk("resp_rd", {59'b0, rd_lsu_o}, {59'b0, e.rd});
          chk("resp_wrtbck", {63'b0, wrtbck_en_lsu_o}, {63'b0, e.wb});
          chk("resp_err", {63'b0, err_lsu_o}, {63'b0, e.err});
          chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  initial begin : stim
    rst             = 1'b1;
    req_valid_lsu_i = 1'b0;
    addr_lsu_i      = '0;
    st_dat_lsu_i    = '0;
    ls_wdth_lsu_i   = '0;
    ls_lsu_i        = 1'b0;
    rd_lsu_i        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'b0, req_ready_lsu_o}, 64'd1);
    chk("rst_resp_valid", {63'b0, resp_valid_lsu_o}, 64'd0);
    chk("rst_mem_req_valid", {63'b0, mem_req_valid_o}, 64'd0);
    chk("rst_ld_dat", ld_dat_lsu_o, 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_mem_wstrb", {56'b0, mem_wstrb_o}, 64'd0);
    chk("rst_err", {63'b0, err_lsu_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Issued back to back: each later request is held until the block is ready again.
    issue(64'h8000_0003, LD, 3'b000, 64'h0, 5'd5, 64'h0000_0000_8000_0000, 0, 0,
          64'hFFFF_FFFF_FFFF_FF80, 1'b0, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0006, LD, 3'b101, 64'h0, 5'd6, 64'hBEEF_0000_0000_0000, 0, 0,
          64'h0000_0000_0000_BEEF, 1'b0, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0004, ST, 3'b010, 64'h1122_3344, 5'd7, 64'h0, 0, 0,
          64'h0, 1'b0, 8'hF0, 64'h1122_3344_0000_0000, 1'b1);
    issue(64'h8000_0002, LD, 3'b010, 64'h0, 5'd8, 64'h0, 0, 0,
          64'h0, 1'b1, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0010, ST, 3'b011, 64'hDEAD_BEEF_CAFE_F00D, 5'd9, 64'h0, 5, 3,
          64'h0, 1'b0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    issue(64'h8000_0102, LD, 3'b001, 64'h0, 5'd10, 64'h0000_0000_8001_0000, 0, 1,
          64'hFFFF_FFFF_FFFF_8001, 1'b0, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0104, LD, 3'b010, 64'h0, 5'd11, 64'h8765_4321_0000_0000, 1, 2,
          64'hFFFF_FFFF_8765_4321, 1'b0, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0104, LD, 3'b110, 64'h0, 5'd12, 64'h8765_4321_0000_0000, 0, 0,
          64'h0000_0000_8765_4321, 1'b0, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0108, LD, 3'b011, 64'h0, 5'd13, 64'h0123_4567_89AB_CDEF, 2, 0,
          64'h0123_4567_89AB_CDEF, 1'b0, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0007, ST, 3'b000, 64'h0000_0000_0000_00AB, 5'd14, 64'h0, 0, 0,
          64'h0, 1'b0, 8'h80, 64'hAB00_0000_0000_0000, 1'b1);
    issue(64'h8000_0002, ST, 3'b001, 64'h0000_0000_0000_BEEF, 5'd15, 64'h0, 0, 0,
          64'h0, 1'b0, 8'h0C, 64'h0000_0000_BEEF_0000, 1'b1);
    issue(64'h8000_0000, ST, 3'b100, 64'h55, 5'd16, 64'h0, 0, 0,
          64'h0, 1'b1, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0000, LD, 3'b111, 64'h0, 5'd17, 64'h0, 0, 0,
          64'h0, 1'b1, 8'h00, 64'h0, 1'b1);
    issue(64'h8000_0004, ST, 3'b011, 64'h1, 5'd18, 64'h0, 0, 0,
          64'h0, 1'b1, 8'h00, 64'h0, 1'b1);
    drain();

    // Reset while in WAIT; the late bus response must be ignored.
    issue(64'h8000_0020, LD, 3'b011, 64'h0, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 0, 6,
          64'h0, 1'b0, 8'h00, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("wait_no_mem_req", {63'b0, mem_req_valid_o}, 64'd0);
    chk("wait_not_ready", {63'b0, req_ready_lsu_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_req_ready", {63'b0, req_ready_lsu_o}, 64'd1);
    chk("abort_resp_valid", {63'b0, resp_valid_lsu_o}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("stale_resp_ready", {63'b0, req_ready_lsu_o}, 64'd1);
    chk("stale_resp_ld_dat", ld_dat_lsu_o, 64'd0);
    drain();

    // Normal operation after the abort; load data then held after the pulse.
    issue(64'h8000_0001, LD, 3'b100, 64'h0, 5'd20, 64'h0000_0000_0000_FF00, 0, 0,
          64'h0000_0000_0000_00FF, 1'b0, 8'h00, 64'h0, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("ld_dat_held", ld_dat_lsu_o, 64'h0000_0000_0000_00FF);
    chk("idle_err_low", {63'b0, err_lsu_o}, 64'd0);
    chk("idle_wrtbck_low", {63'b0, wrtbck_en_lsu_o}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Sits directly downstream of the LSU, replacing its single-cycle combinational dcache hookup with a multi-cycle memory bus master.
- Accepts one load/store request from the LSU via valid/ready.
- Drives a 64-bit request/response memory bus: 8-byte-aligned address, shifted write data, byte strobes.
- Returns the load result to the LSU, right-aligned and sign/zero-extended, plus an error flag.
- One transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 64, LSU data and bus data width; the design is fixed at 64
RD_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid_lsu_i  in  1  LSU request valid
req_ready_lsu_o  out  1  block can accept a request
addr_lsu_i  in  ADDR_WIDTH  effective byte address
st_dat_lsu_i  in  DATA_WIDTH  store data, right-aligned
ls_wdth_lsu_i  in  3  access width/sign code (funct3 encoding)
ls_lsu_i  in  1  LS_LOAD=0, LS_STORE=1
rd_lsu_i  in  RD_WIDTH  load destination register
resp_valid_lsu_o  out  1  one-cycle completion pulse
ld_dat_lsu_o  out  DATA_WIDTH  extended load data
rd_lsu_o  out  RD_WIDTH  latched rd
wrtbck_en_lsu_o  out  1  load completed without error
err_lsu_o  out  1  misaligned access or illegal width
mem_req_valid_o  out  1  bus request valid
mem_req_ready_i  in  1  bus accepts request
mem_addr_o  out  ADDR_WIDTH  address with bits [2:0] forced to 0
mem_wen_o  out  1  1 = write
mem_wdat_o  out  DATA_WIDTH  lane-shifted store data
mem_wstrb_o  out  DATA_WIDTH/8  byte strobes; 0 for reads
mem_resp_valid_i  in  1  bus response or write ack
mem_rdat_i  in  DATA_WIDTH  raw 8-byte read data

Behaviour:
- Width codes: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal. Store decode uses bits [1:0] only; 1xx with a store is illegal.
- Misaligned when the offset off = addr[2:0] is not a multiple of the access size (H: off[0] set; W: off[1:0]≠0; D: off≠0).
- FSM states and transitions:
  - IDLE: req_ready=1. On valid&ready, latch addr, data, width, ls, rd. Illegal or misaligned → RESP with err=1 and no bus activity. Otherwise → REQ.
  - REQ: mem_req_valid=1, with address, wen, wdat and wstrb held stable. On mem_req_ready → WAIT. mem_resp_valid is ignored in REQ.
  - WAIT: on mem_resp_valid, capture mem_rdat (loads only) → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE. req_ready=0 in RESP; no back-to-back acceptance.
- Store lanes:
  - wstrb = size mask (0x01/0x03/0x0F/0xFF) << off.
  - wdat = st_dat << (8*off); bytes outside the strobe are don't-care.
- Load path: shifted = rdat >> (8*off), truncated to size, then sign- or zero-extended to 64 bits per code.
- Response outputs:
  - ld_dat is registered and held stable from RESP until the next accept.
  - wrtbck_en = resp_valid & load & ~err.
  - err is valid only while resp_valid=1.
  - For stores and errors, ld_dat = 0.
- Latency: accept at cycle N, earliest resp_valid at N+3 (REQ at N+1 with ready, WAIT at N+2 with resp). Error path completes at N+1.
- Reset: every output is 0 and state is IDLE, except req_ready_lsu_o=1 in IDLE. Reset mid-transaction aborts to IDLE with no resp_valid. A stale mem_resp_valid arriving in IDLE is ignored.
- Requests presented while not ready are held by the LSU and are not dropped.

Decomposition:
- Add to params.vh: LS_LOAD/LS_STORE, the 3-bit width codes, state encodings, and size masks.
- Sub-module lsu_align (combinational): inputs width code, off, ls; outputs misalign, illegal, wstrb, shifted wdat, and extended load data from raw rdat.
- The FSM and registers live in lsu_mem_ctrl.

Test Plan:
- LB at addr 0x8000_0003, rdat 0x0000_0000_8000_0000 → ld_dat 0xFFFF_FFFF_FFFF_FF80, wrtbck_en=1, err=0, mem_addr 0x8000_0000, wstrb 0x00.
- LHU at 0x...06, rdat 0xBEEF_0000_0000_0000 → ld_dat 0x0000_0000_0000_BEEF.
- SW at 0x...04 with st_dat 0x1122_3344 → wstrb 0xF0, wdat[63:32]=0x1122_3344, resp_valid pulse, wrtbck_en=0.
- LW at 0x...02 → err=1 at N+1, mem_req_valid never asserted, wrtbck_en=0.
- SD with mem_req_ready low for 5 cycles, then response delayed 3 cycles → bus signals stable throughout, exactly one resp_valid.
- rst asserted while in WAIT, then mem_resp_valid arrives → state IDLE, no resp_valid, req_ready=1 next cycle.
